// File: rtl/inst_issue_fifo.sv
// Instruction buffer between fetch and the dual-issue decoder: up to two pushes
// and up to two retirements per cycle, plus the delay-slot flag for inst1_o.
module inst_issue_fifo #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               stall_i,
   input  logic               push1_i,
   input  logic               push2_i,
   input  logic [31:0]        inst1_push_i,
   input  logic [31:0]        addr1_push_i,
   input  logic [31:0]        inst2_push_i,
   input  logic [31:0]        addr2_push_i,
   input  logic               issue_i,
   input  logic               ninst_in_delayslot_i,
   output logic [31:0]        inst1_o,
   output logic [31:0]        inst1_addr_o,
   output logic [31:0]        inst2_o,
   output logic [31:0]        inst2_addr_o,
   output logic               issue_en_o,
   output logic               is_in_delayslot_o,
   output logic               full_o,
   output logic               empty_o,
   output logic [PTR_W:0]     count_o
);

   localparam int       CW          = PTR_W + 1;
   localparam logic     DUAL_ISSUE  = 1'b1;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   logic [31:0]      inst_mem_q [DEPTH];
   logic [31:0]      addr_mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             ds_q, ds_d;

   logic [PTR_W-1:0] rd_p1;
   logic [PTR_W-1:0] wr_p1;
   logic             has1;
   logic             has2;
   logic [1:0]       push_n;
   logic [1:0]       pop_n;

   assign rd_p1 = rd_q + PTR_W'(1);
   assign wr_p1 = wr_q + PTR_W'(1);
   assign has1  = (count_q != '0);
   assign has2  = (count_q >= CW'(2));

   // Handshake: a push is taken only while full_o is low (pairs are all-or-nothing);
   // the head retires whenever issue_en_o is high, 1 or 2 entries per issue_i.
   assign full_o     = (count_q > CW'(DEPTH - 2));
   assign empty_o    = ~has1;
   assign issue_en_o = has1 & ~stall_i & ~flush_i;
   assign count_o    = count_q;
   assign is_in_delayslot_o = ds_q;

   always_comb begin
      push_n = 2'd0;
      if (!full_o && push1_i) begin
         push_n = push2_i ? 2'd2 : 2'd1;
      end
      pop_n = 2'd0;
      if (issue_en_o) begin
         pop_n = (issue_i == DUAL_ISSUE && has2) ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      inst1_o      = ZERO_WORD;
      inst1_addr_o = ZERO_WORD;
      inst2_o      = ZERO_WORD;
      inst2_addr_o = ZERO_WORD;
      if (has1) begin
         inst1_o      = inst_mem_q[rd_q];
         inst1_addr_o = addr_mem_q[rd_q];
      end
      if (has2) begin
         inst2_o      = inst_mem_q[rd_p1];
         inst2_addr_o = addr_mem_q[rd_p1];
      end
   end

   // Occupancy and pops both use pre-push count, so a pushed entry is never read the same cycle.
   always_comb begin
      rd_d    = rd_q + PTR_W'(pop_n);
      wr_d    = wr_q + PTR_W'(push_n);
      count_d = count_q + CW'(push_n) - CW'(pop_n);
      ds_d    = ds_q;
      if (pop_n != 2'd0) begin
         ds_d = (pop_n == 2'd1) & ninst_in_delayslot_i;
      end
      if (flush_i) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
         ds_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ds_q    <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         ds_q    <= ds_d;
      end
   end

   // Storage carries no reset; entries outside [rd, rd+count) are never driven out.
   always_ff @(posedge clk) begin
      if (!flush_i && push_n != 2'd0) begin
         inst_mem_q[wr_q] <= inst1_push_i;
         addr_mem_q[wr_q] <= addr1_push_i;
         if (push_n == 2'd2) begin
            inst_mem_q[wr_p1] <= inst2_push_i;
            addr_mem_q[wr_p1] <= addr2_push_i;
         end
      end
   end

endmodule

// File: tb/tb_inst_issue_fifo.sv
// Bench for inst_issue_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffer's occupancy and delay-slot rules.
module tb_inst_issue_fifo;

   localparam int   DEPTH  = 8;
   localparam int   PTR_W  = 3;
   localparam logic DUAL   = 1'b1;
   localparam logic SINGLE = 1'b0;

   typedef logic [135:0] vec_t;
   localparam vec_t RST_VEC = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 128'd0};

   logic        clk = 1'b0;
   logic        rst, flush_i, stall_i, push1_i, push2_i, issue_i, ninst_in_delayslot_i;
   logic [31:0] inst1_push_i, addr1_push_i, inst2_push_i, addr2_push_i;
   logic [31:0] inst1_o, inst1_addr_o, inst2_o, inst2_addr_o;
   logic        issue_en_o, is_in_delayslot_o, full_o, empty_o;
   logic [PTR_W:0] count_o;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] mq[$];
   logic        m_flag = 1'b0;
   logic [31:0] pc;

   always #5 clk = ~clk;

   inst_issue_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
      .push1_i(push1_i), .push2_i(push2_i),
      .inst1_push_i(inst1_push_i), .addr1_push_i(addr1_push_i),
      .inst2_push_i(inst2_push_i), .addr2_push_i(addr2_push_i),
      .issue_i(issue_i), .ninst_in_delayslot_i(ninst_in_delayslot_i),
      .inst1_o(inst1_o), .inst1_addr_o(inst1_addr_o),
      .inst2_o(inst2_o), .inst2_addr_o(inst2_addr_o),
      .issue_en_o(issue_en_o), .is_in_delayslot_o(is_in_delayslot_o),
      .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
   );

   function automatic vec_t obs_vec();
      return {count_o, full_o, empty_o, issue_en_o, is_in_delayslot_o,
              inst1_o, inst1_addr_o, inst2_o, inst2_addr_o};
   endfunction

   function automatic vec_t exp_vec();
      int n = mq.size();
      logic [31:0] i1 = '0, a1 = '0, i2 = '0, a2 = '0;
      if (n >= 1) {i1, a1} = mq[0];
      if (n >= 2) {i2, a2} = mq[1];
      return {4'(n), (n > DEPTH - 2), (n == 0), (n >= 1) && !stall_i && !flush_i,
              m_flag, i1, a1, i2, a2};
   endfunction

   // Reference behaviour: retire from the front on pre-push size, then append accepted pushes.
   task automatic model_update();
      int n = mq.size();
      int pops = 0;
      if (rst || flush_i) begin
         mq.delete();
         m_flag = 1'b0;
      end else begin
         if (n >= 1 && !stall_i) pops = (issue_i == DUAL && n >= 2) ? 2 : 1;
         for (int k = 0; k < pops; k++) void'(mq.pop_front());
         if (pops > 0) m_flag = (pops == 1) && ninst_in_delayslot_i;
         if (n <= DEPTH - 2 && push1_i) begin
            mq.push_back({inst1_push_i, addr1_push_i});
            if (push2_i) mq.push_back({inst2_push_i, addr2_push_i});
         end
      end
   endtask

   task automatic cycle();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; push1_i = 1'b0; push2_i = 1'b0;
      issue_i = SINGLE; ninst_in_delayslot_i = 1'b0;
   endtask

   task automatic load_pair();
      addr1_push_i = pc;
      addr2_push_i = pc + 32'd4;
      inst1_push_i = $urandom;
      inst2_push_i = $urandom;
      pc = pc + 32'd8;
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1;
      cycle(); cycle();
      total++;
      if (obs_vec() !== RST_VEC) begin
         bad++; $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), RST_VEC);
      end
      rst = 1'b0; #1;
      total++;
      if (obs_vec() !== RST_VEC) begin
         bad++; $display("FAIL reset_after obs=%h exp=%h", obs_vec(), RST_VEC);
      end
   endtask

   task automatic test_first_pair();
      idle(); push1_i = 1'b1; push2_i = 1'b1; issue_i = DUAL;
      inst1_push_i = 32'h2401_0001; addr1_push_i = 32'hBFC0_0000;
      inst2_push_i = 32'h2402_0002; addr2_push_i = 32'hBFC0_0004;
      cycle();
      push1_i = 1'b0; push2_i = 1'b0; #1;
      total++;
      if (count_o !== 4'd2 || inst2_addr_o !== 32'hBFC0_0004 || inst1_o !== 32'h2401_0001) begin
         bad++; $display("FAIL first_pair_visible count=%0d addr2=%h inst1=%h exp 2/bfc00004/24010001",
                         count_o, inst2_addr_o, inst1_o);
      end
      cycle();
      total++;
      if (count_o !== 4'd0 || empty_o !== 1'b1) begin
         bad++; $display("FAIL first_pair_drained count=%0d empty=%b exp 0/1", count_o, empty_o);
      end
   endtask

   task automatic test_dual_on_one();
      idle(); push1_i = 1'b1; pc = 32'h0000_1000; load_pair();
      cycle();
      push1_i = 1'b0; issue_i = DUAL; #1;
      total++;
      if (inst2_o !== 32'd0 || count_o !== 4'd1 || issue_en_o !== 1'b1) begin
         bad++; $display("FAIL dual_on_one inst2=%h count=%0d en=%b exp 0/1/1", inst2_o, count_o, issue_en_o);
      end
      cycle();
      total++;
      if (count_o !== 4'd0) begin
         bad++; $display("FAIL dual_on_one_after count=%0d exp 0", count_o);
      end
   endtask

   task automatic test_full();
      idle(); stall_i = 1'b1; push1_i = 1'b1; push2_i = 1'b1; pc = 32'h0000_2000;
      for (int k = 0; k < 3; k++) begin load_pair(); cycle(); end
      push2_i = 1'b0; load_pair(); cycle();
      push2_i = 1'b1; load_pair(); #1;
      total++;
      if (full_o !== 1'b1 || count_o !== 4'd7) begin
         bad++; $display("FAIL full_flag full=%b count=%0d exp 1/7", full_o, count_o);
      end
      cycle();
      total++;
      if (count_o !== 4'd7 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL full_push_ignored obs=%h exp=%h", obs_vec(), exp_vec());
      end
      stall_i = 1'b0; issue_i = SINGLE; load_pair();
      cycle();
      total++;
      if (count_o !== 4'd6 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL full_single_pop obs=%h exp=%h", obs_vec(), exp_vec());
      end
      idle(); flush_i = 1'b1; cycle();
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc;
      idle(); pc = 32'h8000_0000; exp_pc = 32'h8000_0000;
      push1_i = 1'b1; push2_i = 1'b1; issue_i = DUAL;
      for (int k = 0; k < 20; k++) begin
         load_pair(); #1;
         if (mq.size() >= 2) begin
            total++;
            if (inst1_addr_o !== exp_pc || inst2_addr_o !== exp_pc + 32'd4) begin
               bad++; $display("FAIL wrap_order addr1=%h addr2=%h exp %h/%h",
                               inst1_addr_o, inst2_addr_o, exp_pc, exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd8;
         end
         cycle();
      end
      push1_i = 1'b0; push2_i = 1'b0; cycle(); #1;
      total++;
      if (empty_o !== 1'b1 || exp_pc !== pc - 32'd8) begin
         bad++; $display("FAIL wrap_drain empty=%b last_pc=%h exp 1/%h", empty_o, exp_pc, pc - 32'd8);
      end
   endtask

   task automatic test_delayslot();
      idle(); stall_i = 1'b1; push1_i = 1'b1; push2_i = 1'b1; pc = 32'h0000_3000;
      load_pair(); cycle(); load_pair(); cycle();
      idle(); issue_i = SINGLE; ninst_in_delayslot_i = 1'b1;
      cycle();
      total++;
      if (is_in_delayslot_o !== 1'b1 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL ds_set obs=%h exp=%h", obs_vec(), exp_vec());
      end
      stall_i = 1'b1; ninst_in_delayslot_i = 1'b0;
      cycle();
      total++;
      if (is_in_delayslot_o !== 1'b1) begin
         bad++; $display("FAIL ds_hold_stall ds=%b exp 1", is_in_delayslot_o);
      end
      stall_i = 1'b0;
      cycle();
      total++;
      if (is_in_delayslot_o !== 1'b0 || obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL ds_clear obs=%h exp=%h", obs_vec(), exp_vec());
      end
      idle(); flush_i = 1'b1; cycle();
   endtask

   task automatic test_flush_reset();
      idle(); stall_i = 1'b1; push1_i = 1'b1; push2_i = 1'b1; pc = 32'h0000_4000;
      for (int k = 0; k < 3; k++) begin load_pair(); cycle(); end
      idle(); issue_i = SINGLE; ninst_in_delayslot_i = 1'b1; cycle(); #1;
      total++;
      if (count_o !== 4'd5 || is_in_delayslot_o !== 1'b1) begin
         bad++; $display("FAIL flush_setup count=%0d ds=%b exp 5/1", count_o, is_in_delayslot_o);
      end
      flush_i = 1'b1; push1_i = 1'b1; load_pair();
      cycle();
      total++;
      if (count_o !== 4'd0 || empty_o !== 1'b1 || is_in_delayslot_o !== 1'b0) begin
         bad++; $display("FAIL flush_clear count=%0d empty=%b ds=%b exp 0/1/0",
                         count_o, empty_o, is_in_delayslot_o);
      end
      idle(); push1_i = 1'b1; push2_i = 1'b1; stall_i = 1'b1;
      load_pair(); cycle(); load_pair(); cycle();
      rst = 1'b1; flush_i = 1'b0; load_pair(); cycle();
      idle(); #1;
      total++;
      if (obs_vec() !== RST_VEC) begin
         bad++; $display("FAIL reset_midfill obs=%h exp=%h", obs_vec(), RST_VEC);
      end
   endtask

   task automatic test_random();
      pc = 32'h0001_0000;
      for (int k = 0; k < 500; k++) begin
         rst     = ($urandom_range(0, 149) == 0);
         flush_i = ($urandom_range(0, 24) == 0);
         stall_i = ($urandom_range(0, 3) == 0);
         push1_i = ($urandom_range(0, 2) != 0);
         push2_i = $urandom_range(0, 1);
         issue_i = $urandom_range(0, 1);
         ninst_in_delayslot_i = $urandom_range(0, 1);
         load_pair(); #1;
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL random_%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
         end
         cycle();
      end
      idle();
   endtask

   initial begin
      idle(); rst = 1'b1; pc = '0;
      inst1_push_i = '0; addr1_push_i = '0; inst2_push_i = '0; addr2_push_i = '0;
      @(posedge clk); #1;
      test_reset();
      test_first_pair();
      test_dual_on_one();
      test_full();
      test_wrap();
      test_delayslot();
      test_flush_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_issue_fifo.md
INST_ISSUE_FIFO -- requirements
Module: inst_issue_fifo

Instruction buffer between fetch and the dual-issue decode stage. It accepts up to 2 instructions per cycle from fetch and presents the two oldest to decode. It retires 1 or 2 entries per cycle according to the decoder's issue decision, and tracks the delay-slot flag across single-issue boundaries.

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of 2, >=4).
REQ-002 SHALL have parameter PTR_W, default 3, pointer width = log2(DEPTH).
REQ-003 SHALL have one clock and a synchronous, active-high reset; both ports are listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset; synchronous, active-high (`RstEnable).
REQ-006 flush_i  in  1  discard all contents (exception/redirect).
REQ-007 stall_i  in  1  back-end stall; no entry retired.
REQ-008 push1_i  in  1  write the inst1_push_i/addr1_push_i pair.
REQ-009 push2_i  in  1  write the second pair; legal only with push1_i.
REQ-010 inst1_push_i, addr1_push_i, inst2_push_i, addr2_push_i  in  32 each  fetched words and PCs.
REQ-011 issue_i  in  1  decoder issue decision (`DualIssue / `SingleIssue).
REQ-012 ninst_in_delayslot_i  in  1  decoder flag: next inst1 is a delay slot.
REQ-013 inst1_o, inst1_addr_o  out  32 each  head entry.
REQ-014 inst2_o, inst2_addr_o  out  32 each  head+1 entry.
REQ-015 issue_en_o  out  1  head entry valid and retirable this cycle.
REQ-016 is_in_delayslot_o  out  1  inst1_o is a delay-slot instruction.
REQ-017 full_o  out  1  fewer than 2 free entries.
REQ-018 empty_o  out  1  count==0.
REQ-019 count_o  out  PTR_W+1  occupancy, 0..DEPTH.

Function
REQ-020 SHALL use read pointer rd, write pointer wr and count, with rd and wr wrapping modulo DEPTH.
REQ-021 SHALL drive inst1_o/inst1_addr_o combinationally from entry rd when count>=1, else `ZeroWord.
REQ-022 SHALL drive inst2_o/inst2_addr_o from entry rd+1 (mod DEPTH) when count>=2, else `ZeroWord (NOP).
REQ-023 SHALL assert full_o iff count > DEPTH-2, and empty_o iff count==0.
REQ-024 SHALL ignore push1_i and push2_i when full_o is set, with no partial write.
REQ-025 SHALL, when not full: push1_i alone writes 1 entry at wr; push1_i with push2_i writes pair 1 at wr and pair 2 at wr+1; push2_i without push1_i is ignored.
REQ-026 SHALL compute issue_en_o = (count>=1) & ~stall_i & ~flush_i.
REQ-027 SHALL set the pop count to: 0 if issue_en_o=0; 2 if issue_i=`DualIssue and count>=2; otherwise 1.
REQ-028 SHALL evaluate pops on pre-push occupancy (no write-to-read bypass); entries pushed in cycle N become visible at cycle N+1.
REQ-029 SHALL update count_next = count + pushes - pops, never exceeding DEPTH or going below 0.
REQ-030 SHALL, on pop>0, set the delay-slot flag next = (pop==1) & ninst_in_delayslot_i; with pop==0 the flag holds.
REQ-031 SHALL register is_in_delayslot_o directly from the delay-slot flag.
REQ-032 SHALL, on flush_i=1, set rd=wr=0, count=0 and flag=0 next cycle, and discard pushes in that cycle.
REQ-033 SHALL give flush_i priority over push, pop and stall_i.

Reset
REQ-034 SHALL, on rst=1 at the clock edge, set rd, wr, count and the flag to 0; rst has priority over flush_i.
REQ-035 SHALL, during and after reset: empty_o=1, full_o=0, issue_en_o=0, count_o=0, inst*_o=0, is_in_delayslot_o=0.
REQ-036 SHALL NOT reset the data array; content of invalid entries is never observable.

Verification
REQ-037 Reset, then push pair (0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004), issue_i=Dual -> next cycle count_o=2 and inst2_addr_o=0xBFC00004; following cycle count_o=0, empty_o=1.
REQ-038 count=1, issue_i=Dual, no stall -> pop 1, inst2_o=0 while count=1, count_o=0 after.
REQ-039 Fill to count=7 -> full_o=1; push pair -> ignored, count_o stays 7; the same cycle with Single issue -> count_o=6.
REQ-040 Pointer wrap: 20 cycles of push-pair + dual-pop -> addresses presented in strict PC order, no loss or duplication.
REQ-041 Branch at head, Single issue, ninst_in_delayslot_i=1 -> is_in_delayslot_o=1 next cycle; stall_i=1 holds it at 1; next pop with ninst_in_delayslot_i=0 clears it.
REQ-042 count=5 with flush_i and push1_i asserted together -> count_o=0, empty_o=1, is_in_delayslot_o=0 next cycle; rst mid-fill -> REQ-035 values.
